// File: rtl/spy_chain_sequencer_if.sv
// Bundle between the spy-chain sequencer, its readout logic and the delay chain.
// The slave side is the sequencer; the master side starts runs and returns the chain output.
interface spy_chain_sequencer_if #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TRIALS_LOG2 = 4
);
  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         timeout_err;
  logic [CNT_W+TRIALS_LOG2-1:0] lat_sum;
  logic [CNT_W-1:0]             lat_min;
  logic [CNT_W-1:0]             lat_max;
  logic                         path_input;
  logic                         path_result;

  modport master (
    output start, path_result,
    input  busy, done, timeout_err, lat_sum, lat_min, lat_max, path_input
  );

  modport slave (
    input  start, path_result,
    output busy, done, timeout_err, lat_sum, lat_min, lat_max, path_input
  );
endinterface

// File: rtl/spy_chain_sequencer.sv
// Launches alternating edges into a spy delay chain and measures, in clock cycles, how long each
// edge takes to reappear at the synchronized chain output; keeps sum/min/max over a run.
module spy_chain_sequencer #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TRIALS_LOG2 = 4,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned INVERT      = 0
) (
  input logic                  clk,
  input logic                  rst,
  spy_chain_sequencer_if.slave bus
);

  localparam int unsigned SUM_W = CNT_W + TRIALS_LOG2;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [SET_W-1:0]     settleLast = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]     timeoutVal = CNT_W'(TIMEOUT);
  localparam logic [TRIALS_LOG2:0] numTrials  = {1'b1, {TRIALS_LOG2{1'b0}}};
  localparam logic                 invBit     = (INVERT != 0);

  typedef enum logic [2:0] {StIdle, StSettle, StMeasure, StAccum, StDone} stateE;

  stateE                stateQ;
  logic                 s1, s2;
  logic [SET_W-1:0]     settleCnt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     lat;
  logic [TRIALS_LOG2:0] trial;

  logic                 busyQ;
  logic                 doneQ;
  logic                 timeoutErrQ;
  logic [SUM_W-1:0]     latSumQ;
  logic [CNT_W-1:0]     latMinQ;
  logic [CNT_W-1:0]     latMaxQ;
  logic                 pathInputQ;

  logic [CNT_W-1:0]     cntInc;
  logic [TRIALS_LOG2:0] trialInc;
  logic [SUM_W-1:0]     latExt;
  logic                 expected;

  assign cntInc   = cnt + CNT_W'(1);
  assign trialInc = trial + (TRIALS_LOG2 + 1)'(1);
  assign latExt   = {{TRIALS_LOG2{1'b0}}, lat};
  assign expected = pathInputQ ^ invBit;

  assign bus.busy        = busyQ;
  assign bus.done        = doneQ;
  assign bus.timeout_err = timeoutErrQ;
  assign bus.lat_sum     = latSumQ;
  assign bus.lat_min     = latMinQ;
  assign bus.lat_max     = latMaxQ;
  assign bus.path_input  = pathInputQ;

  // path_result is asynchronous to clk; only s2 is ever looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.path_result;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ      <= StIdle;
      settleCnt   <= '0;
      cnt         <= '0;
      lat         <= '0;
      trial       <= '0;
      busyQ       <= 1'b0;
      doneQ       <= 1'b0;
      timeoutErrQ <= 1'b0;
      latSumQ     <= '0;
      latMinQ     <= '1;
      latMaxQ     <= '0;
      pathInputQ  <= 1'b0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (bus.start) begin
            busyQ       <= 1'b1;
            timeoutErrQ <= 1'b0;
            latSumQ     <= '0;
            latMinQ     <= '1;
            latMaxQ     <= '0;
            trial       <= '0;
            settleCnt   <= '0;
            stateQ      <= StSettle;
          end
        end
        StSettle: begin
          if (settleCnt == settleLast) begin
            pathInputQ <= ~pathInputQ;
            cnt        <= '0;
            stateQ     <= StMeasure;
          end else begin
            settleCnt <= settleCnt + SET_W'(1);
          end
        end
        StMeasure: begin
          if (s2 == expected) begin
            lat    <= cntInc;
            stateQ <= StAccum;
          end else if (cntInc == timeoutVal) begin
            // Abort leaves the partial accumulators visible to the readout.
            timeoutErrQ <= 1'b1;
            busyQ       <= 1'b0;
            doneQ       <= 1'b1;
            stateQ      <= StDone;
          end else begin
            cnt <= cntInc;
          end
        end
        StAccum: begin
          latSumQ   <= latSumQ + latExt;
          trial     <= trialInc;
          settleCnt <= '0;
          if (lat < latMinQ) latMinQ <= lat;
          if (lat > latMaxQ) latMaxQ <= lat;
          if (trialInc == numTrials) begin
            busyQ  <= 1'b0;
            doneQ  <= 1'b1;
            stateQ <= StDone;
          end else begin
            stateQ <= StSettle;
          end
        end
        StDone: begin
          doneQ  <= 1'b0;
          stateQ <= StIdle;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spy_chain_sequencer.sv
// Runs five sequencer instances against behavioural chain models and scores each run's results.
module tb_spy_chain_sequencer;

  typedef struct {
    int id;
    int sum;
    int mn;
    int mx;
    int terr;
    int doneEdge;
    bit poke;
  } vecT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  spy_chain_sequencer_if #(.CNT_W(8), .TRIALS_LOG2(4)) ifA ();
  spy_chain_sequencer_if #(.CNT_W(8), .TRIALS_LOG2(2)) ifB ();
  spy_chain_sequencer_if #(.CNT_W(8), .TRIALS_LOG2(4)) ifC ();
  spy_chain_sequencer_if #(.CNT_W(8), .TRIALS_LOG2(4)) ifD ();
  spy_chain_sequencer_if #(.CNT_W(8), .TRIALS_LOG2(4)) ifE ();

  spy_chain_sequencer #(.TRIALS_LOG2(4)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  spy_chain_sequencer #(.TRIALS_LOG2(2)) dutB (.clk(clk), .rst(rst), .bus(ifB));
  spy_chain_sequencer #(.TRIALS_LOG2(4)) dutC (.clk(clk), .rst(rst), .bus(ifC));
  spy_chain_sequencer #(.TRIALS_LOG2(4)) dutD (.clk(clk), .rst(rst), .bus(ifD));
  spy_chain_sequencer #(.TRIALS_LOG2(4), .INVERT(1)) dutE (.clk(clk), .rst(rst), .bus(ifE));

  // Chain models: zero delay, 5-cycle line, 2-rise/6-fall, stuck low, zero-delay inverting.
  logic [4:0] dlB;
  logic [5:0] dlC;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dlB <= '0;
      dlC <= '0;
    end else begin
      dlB <= {dlB[3:0], ifB.path_input};
      dlC <= {dlC[4:0], ifC.path_input};
    end
  end
  assign ifA.path_result = ifA.path_input;
  assign ifB.path_result = dlB[4];
  assign ifC.path_result = dlC[1] | dlC[5];
  assign ifD.path_result = 1'b0;
  assign ifE.path_result = ~ifE.path_input;

  logic startV [5];
  logic busyV  [5];
  logic doneV  [5];
  int   terrV  [5];
  int   sumV   [5];
  int   minV   [5];
  int   maxV   [5];

  assign ifA.start = startV[0];
  assign ifB.start = startV[1];
  assign ifC.start = startV[2];
  assign ifD.start = startV[3];
  assign ifE.start = startV[4];

  assign busyV[0] = ifA.busy;  assign doneV[0] = ifA.done;  assign terrV[0] = int'(ifA.timeout_err);
  assign busyV[1] = ifB.busy;  assign doneV[1] = ifB.done;  assign terrV[1] = int'(ifB.timeout_err);
  assign busyV[2] = ifC.busy;  assign doneV[2] = ifC.done;  assign terrV[2] = int'(ifC.timeout_err);
  assign busyV[3] = ifD.busy;  assign doneV[3] = ifD.done;  assign terrV[3] = int'(ifD.timeout_err);
  assign busyV[4] = ifE.busy;  assign doneV[4] = ifE.done;  assign terrV[4] = int'(ifE.timeout_err);
  assign sumV[0] = int'(ifA.lat_sum);  assign minV[0] = int'(ifA.lat_min);
  assign sumV[1] = int'(ifB.lat_sum);  assign minV[1] = int'(ifB.lat_min);
  assign sumV[2] = int'(ifC.lat_sum);  assign minV[2] = int'(ifC.lat_min);
  assign sumV[3] = int'(ifD.lat_sum);  assign minV[3] = int'(ifD.lat_min);
  assign sumV[4] = int'(ifE.lat_sum);  assign minV[4] = int'(ifE.lat_min);
  assign maxV[0] = int'(ifA.lat_max);
  assign maxV[1] = int'(ifB.lat_max);
  assign maxV[2] = int'(ifC.lat_max);
  assign maxV[3] = int'(ifD.lat_max);
  assign maxV[4] = int'(ifE.lat_max);

  // Count path_input transitions of instance A.
  logic prevA = 1'b0;
  int   togA  = 0;
  always @(posedge clk) begin
    prevA <= ifA.path_input;
    if (prevA != ifA.path_input) togA <= togA + 1;
  end

  vecT sb[$];
  vecT vecs[5];

  task automatic check(input string name, input int id, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[dut%0d]: got %0d want %0d", name, id, act, exp);
    end
  endtask

  task automatic runVec(input vecT v);
    vecT e;
    int  edges;
    int  extra;
    int  togBefore;
    sb.push_back(v);
    togBefore = togA;
    @(negedge clk);
    startV[v.id] = 1'b1;
    @(posedge clk);  // edge 0
    #1;
    startV[v.id] = 1'b0;
    check("busy_after_start", v.id, int'(busyV[v.id]), 1);
    edges = 0;
    while (!doneV[v.id] && edges < 1000) begin
      @(posedge clk);
      #1;
      edges++;
      startV[v.id] = v.poke && (edges == 20 || edges == 60);
    end
    startV[v.id] = 1'b0;
    e = sb.pop_front();
    check("done_seen", e.id, int'(doneV[e.id]), 1);
    check("done_edge", e.id, edges, e.doneEdge);
    check("busy_in_done", e.id, int'(busyV[e.id]), 0);
    check("lat_sum", e.id, sumV[e.id], e.sum);
    check("lat_min", e.id, minV[e.id], e.mn);
    check("lat_max", e.id, maxV[e.id], e.mx);
    check("timeout_err", e.id, terrV[e.id], e.terr);
    @(posedge clk);
    #1;
    check("done_one_cycle", e.id, int'(doneV[e.id]), 0);
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (doneV[e.id]) extra++;
    end
    check("extra_done", e.id, extra, 0);
    check("lat_sum_hold", e.id, sumV[e.id], e.sum);
    if (e.id == 0) begin
      check("toggles", e.id, togA - togBefore, 16);
      check("path_input_end", e.id, int'(ifA.path_input), 0);
    end
  endtask

  initial begin
    int extra;
    // Expected done edge = sum over trials of (SETTLE + lat + 1).
    vecs[0] = '{0, 16 * 3, 3, 3, 0, 16 * (4 + 1) + 16 * 3, 1'b0};
    vecs[1] = '{1, 4 * 8, 8, 8, 0, 4 * (4 + 1) + 4 * 8, 1'b0};
    vecs[2] = '{2, 8 * 5 + 8 * 9, 5, 9, 0, 16 * (4 + 1) + 8 * 5 + 8 * 9, 1'b0};
    vecs[3] = '{3, 0, 255, 0, 1, 4 + 200, 1'b0};
    vecs[4] = '{4, 16 * 3, 3, 3, 0, 16 * (4 + 1) + 16 * 3, 1'b1};
    for (int i = 0; i < 5; i++) startV[i] = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", 0, int'(busyV[0]), 0);
    check("rst_done", 0, int'(doneV[0]), 0);
    check("rst_terr", 0, terrV[0], 0);
    check("rst_sum", 0, sumV[0], 0);
    check("rst_min", 0, minV[0], 255);
    check("rst_max", 0, maxV[0], 0);
    check("rst_path_input", 0, int'(ifA.path_input), 0);

    for (int i = 0; i < 5; i++) runVec(vecs[i]);

    // Reset in the middle of a run abandons it silently.
    @(negedge clk);
    startV[0] = 1'b1;
    @(posedge clk);
    #1;
    startV[0] = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("mid_sum_nonzero", 0, int'(sumV[0] != 0), 1);
    rst = 1'b1;
    #1;
    check("mrst_busy", 0, int'(busyV[0]), 0);
    check("mrst_done", 0, int'(doneV[0]), 0);
    check("mrst_path_input", 0, int'(ifA.path_input), 0);
    check("mrst_sum", 0, sumV[0], 0);
    check("mrst_min", 0, minV[0], 255);
    check("mrst_max", 0, maxV[0], 0);
    check("mrst_terr", 0, terrV[0], 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (doneV[0] || busyV[0]) extra++;
    end
    check("mrst_no_done", 0, extra, 0);
    runVec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
